// File: rtl/vga_scanout_if.sv
// Frame-buffer read port between the VGA scan-out engine (master) and the
// colour frame buffer (slave). Read data is valid one clock after RE.
interface vga_scanout_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] rAddr;
    logic              RE;
    logic [2:0]        dataOut;

    modport master (output rAddr, output RE, input dataOut);
    modport slave  (input rAddr, input RE, output dataOut);
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out of a pixel-doubled 320x240 3-bit frame buffer.
// Optional VGA_TEST_PATTERN_EN adds frame-latched colour bars on test_mode.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FB_W      = 320,
    parameter int ADDR_W    = 17
) (
    input  logic                clock,
    input  logic                reset_n,
    vga_scanout_if.master       fb,
    input  logic                test_mode,
    output logic [2:0]          rgb,
    output logic                hsync,
    output logic                vsync,
    output logic                vblank,
    output logic                frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_C    = 10'(V_VISIBLE);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [ADDR_W-1:0] FB_W_C   = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    logic [9:0]        h_cnt_r, v_cnt_r;
    logic [ADDR_W-1:0] addr_r, base_r, addr_nxt_s, base_nxt_s;
    logic              active_s, hs_s, vs_s, vblank_s, first_s, re_s;
    logic              line_end_s, frame_end_s;
    logic              active_d1_r, hs_d1_r, vs_d1_r, vblank_d1_r, first_d1_r;
    logic              active_d2_r, hs_d2_r, vs_d2_r, vblank_d2_r, first_d2_r;
    logic [2:0]        rgb_nxt_s;

    // Horizontal and vertical raster counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= (v_cnt_r == V_LAST) ? 10'd0 : v_cnt_r + 10'd1;
        end else begin
            h_cnt_r <= h_cnt_r + 10'd1;
            v_cnt_r <= v_cnt_r;
        end
    end

    // Stage 0 decode of the current raster position
    always_comb begin
        active_s    = (h_cnt_r < H_VIS_C) && (v_cnt_r < V_VIS_C);
        hs_s        = !((h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST));
        vs_s        = !((v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST));
        vblank_s    = (v_cnt_r >= V_VIS_C);
        first_s     = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
        line_end_s  = (h_cnt_r == H_LAST);
        frame_end_s = line_end_s && (v_cnt_r == V_LAST);
    end

    // Buffer address walk: each row fetched twice, each pixel held two clocks
    always_comb begin
        addr_nxt_s = addr_r;
        base_nxt_s = base_r;
        if (frame_end_s) begin
            addr_nxt_s = ADDR_ZERO;
            base_nxt_s = ADDR_ZERO;
        end else if (line_end_s) begin
            if (v_cnt_r[0] && (v_cnt_r < V_VIS_C)) begin
                // after the last visible row the walk parks at 0 so the
                // address never points past the end of the buffer
                if (v_cnt_r == V_VIS_LAST) begin
                    addr_nxt_s = ADDR_ZERO;
                    base_nxt_s = ADDR_ZERO;
                end else begin
                    addr_nxt_s = base_r + FB_W_C;
                    base_nxt_s = base_r + FB_W_C;
                end
            end else begin
                addr_nxt_s = base_r;
                base_nxt_s = base_r;
            end
        end else if (active_s && h_cnt_r[0]) begin
            addr_nxt_s = addr_r + ADDR_ONE;
            base_nxt_s = base_r;
        end else begin
            addr_nxt_s = addr_r;
            base_nxt_s = base_r;
        end
    end

    // Address and row-base registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_r <= ADDR_ZERO;
            base_r <= ADDR_ZERO;
        end else begin
            addr_r <= addr_nxt_s;
            base_r <= base_nxt_s;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic       tm_frame_r;
    logic [2:0] pat_d1_r, pat_d2_r;
    logic       pat_en_d1_r, pat_en_d2_r;

    // Test-mode select latched only at the frame wrap to avoid mid-frame switching
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tm_frame_r <= 1'b0;
        end else if (frame_end_s) begin
            tm_frame_r <= test_mode;
        end else begin
            tm_frame_r <= tm_frame_r;
        end
    end

    // Colour-bar value and mode flag delayed alongside the read pipeline
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_d1_r    <= 3'd0;
            pat_d2_r    <= 3'd0;
            pat_en_d1_r <= 1'b0;
            pat_en_d2_r <= 1'b0;
        end else begin
            pat_d1_r    <= h_cnt_r[9:7];
            pat_d2_r    <= pat_d1_r;
            pat_en_d1_r <= tm_frame_r;
            pat_en_d2_r <= pat_en_d1_r;
        end
    end

    assign re_s = active_s && !tm_frame_r;
`else
    logic unused_test_mode_s;

    assign unused_test_mode_s = test_mode;
    assign re_s = active_s;
`endif

    // Stage 1: read request and first delay of the timing flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fb.rAddr    <= ADDR_ZERO;
            fb.RE       <= 1'b0;
            active_d1_r <= 1'b0;
            hs_d1_r     <= 1'b1;
            vs_d1_r     <= 1'b1;
            vblank_d1_r <= 1'b0;
            first_d1_r  <= 1'b0;
        end else begin
            fb.rAddr    <= addr_r;
            fb.RE       <= re_s;
            active_d1_r <= active_s;
            hs_d1_r     <= hs_s;
            vs_d1_r     <= vs_s;
            vblank_d1_r <= vblank_s;
            first_d1_r  <= first_s;
        end
    end

    // Stage 2: timing flags wait while the buffer returns data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active_d2_r <= 1'b0;
            hs_d2_r     <= 1'b1;
            vs_d2_r     <= 1'b1;
            vblank_d2_r <= 1'b0;
            first_d2_r  <= 1'b0;
        end else begin
            active_d2_r <= active_d1_r;
            hs_d2_r     <= hs_d1_r;
            vs_d2_r     <= vs_d1_r;
            vblank_d2_r <= vblank_d1_r;
            first_d2_r  <= first_d1_r;
        end
    end

    // Pixel colour selection with blanking outside the active area
    always_comb begin
        rgb_nxt_s = 3'd0;
        if (active_d2_r) begin
`ifdef VGA_TEST_PATTERN_EN
            if (pat_en_d2_r) begin
                rgb_nxt_s = pat_d2_r;
            end else begin
                rgb_nxt_s = fb.dataOut;
            end
`else
            rgb_nxt_s = fb.dataOut;
`endif
        end else begin
            rgb_nxt_s = 3'd0;
        end
    end

    // Stage 3: pin registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rgb         <= 3'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            rgb         <= rgb_nxt_s;
            hsync       <= hs_d2_r;
            vsync       <= vs_d2_r;
            vblank      <= vblank_d2_r;
            frame_start <= first_d2_r;
        end
    end

endmodule
